if_fetch_unit: RTL and testbench

//  Instruction-fetch stage: the producer of inst / pc / pcPlus4 consumed by the decode stage.

---
 rtl/if_fetch_unit_if.sv | 26 ++
 rtl/if_fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory channel between the fetch unit and imem.
// Request: valid/ready handshake carrying a word-aligned address.
// Response: in-order read data, at most one word per cycle.
interface if_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: issues in-order word fetches to imem, buffers the
// returned words in a prefetch FIFO and presents the FIFO head to decode.
// Handles redirects from EX (flush + discard of in-flight responses) and
// decode stalls.
// Optional build macro IF_NOP_INSERT_EN: while inst_valid=0 the inst output
// carries addi x0,x0,0 instead of the last head word.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            reset,
  if_fetch_unit_if.master imem,
  input  logic            redirect_valid,
  input  logic [31:0]     redirect_pc,
  input  logic            stall,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [31:0]     pc_out,
  output logic [31:0]     pcPlus4_out
);

  localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW      = PW + 1;
  localparam int          OW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] DEPTH_W = 32'(FIFO_DEPTH);
  localparam logic [31:0] MAXO_W  = 32'(MAX_OUTSTANDING);
`ifdef IF_NOP_INSERT_EN
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
`endif

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;      // pc of the next response that will be kept
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] discard_q, discard_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   fifo_inst_q [FIFO_DEPTH];
  logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]   hold_pc_q;
`ifndef IF_NOP_INSERT_EN
  logic [31:0]   hold_inst_q;
`endif

  logic        credit_ok;
  logic        req_valid;
  logic        xfer;
  logic        rsp_acc;
  logic        rsp_drop;
  logic        push;
  logic        pop;
  logic        fifo_empty;
  logic [31:0] target_pc;
  logic [31:0] head_inst;
  logic [31:0] head_pc;

  // Credit rule keeps in-flight plus buffered words within the FIFO, so a
  // returning response always has a slot. Responses seen with nothing in
  // flight belong to pre-reset requests and are ignored.
  always_comb begin
    credit_ok  = (32'(outst_q) < MAXO_W) &&
                 ((32'(outst_q) + 32'(count_q)) < DEPTH_W);
    req_valid  = credit_ok && !reset;
    xfer       = req_valid && imem.imem_req_ready;
    rsp_acc    = imem.imem_rsp_valid && (outst_q != '0);
    rsp_drop   = rsp_acc && (discard_q != '0);
    fifo_empty = (count_q == '0);
    push       = rsp_acc && !rsp_drop && !redirect_valid;
    pop        = !fifo_empty && !stall && !redirect_valid;
    target_pc  = redirect_pc & 32'hFFFF_FFFC;
    head_inst  = fifo_inst_q[rd_ptr_q];
    head_pc    = fifo_pc_q[rd_ptr_q];
  end

  // Next-state for fetch address, in-flight bookkeeping and FIFO pointers.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    outst_d    = outst_q + OW'(xfer) - OW'(rsp_acc);
    discard_d  = discard_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      // Everything still in flight after this cycle is stale.
      fetch_pc_d = target_pc;
      rsp_pc_d   = target_pc;
      discard_d  = outst_d;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (xfer) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (rsp_drop) begin
        discard_d = discard_q - OW'(1);
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
      end
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      hold_pc_q  <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      if (!fifo_empty) begin
        hold_pc_q <= head_pc;
      end
    end
  end

  // Prefetch storage; contents are only meaningful below count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst_q[wr_ptr_q] <= imem.imem_rsp_data;
      fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
    end
  end

`ifndef IF_NOP_INSERT_EN
  // Last presented word, shown again while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_inst_q <= '0;
    end else if (!fifo_empty) begin
      hold_inst_q <= head_inst;
    end
  end
`endif

  // Decode-facing outputs and imem request.
  always_comb begin
    imem.imem_req_valid = req_valid;
    imem.imem_addr      = fetch_pc_q;
    inst_valid          = !fifo_empty;
    pc_out              = fifo_empty ? hold_pc_q : head_pc;
    pcPlus4_out         = pc_out + 32'd4;
`ifdef IF_NOP_INSERT_EN
    inst                = fifo_empty ? NOP_INST : head_inst;
`else
    inst                = fifo_empty ? hold_inst_q : head_inst;
`endif
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: an imem model answers requests in
// order, and a scoreboard of expected fetch pcs is filled on every request
// transfer and drained as decode consumes instructions.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IF_NOP_INSERT_EN
  localparam logic [31:0] IDLE_INST_RST = 32'h0000_0013;
  localparam bit          NOP_MODE      = 1'b1;
`else
  localparam logic [31:0] IDLE_INST_RST = 32'h0000_0000;
  localparam bit          NOP_MODE      = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc_out;
  logic [31:0] pcPlus4_out;

  if_fetch_unit_if imem();

  if_fetch_unit #(
    .RESET_PC(RESET_PC),
    .FIFO_DEPTH(4),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .imem(imem),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .stall(stall),
    .inst_valid(inst_valid),
    .inst(inst),
    .pc_out(pc_out),
    .pcPlus4_out(pcPlus4_out)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  bit          mon_en   = 1'b0;
  bit          mem_hold = 1'b0;
  logic [31:0] exp_fetch;
  logic [31:0] exp_q[$];
  logic [31:0] pend_q[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hA5C3_0F01;
  endfunction

  // Scoreboard and imem request recorder, sampled on the falling edge.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (mon_en && !reset) begin
        if (imem.imem_req_valid === 1'b1) begin
          checks++;
          if (imem.imem_addr !== exp_fetch) begin
            failures++;
            $display("FAIL sb_addr: imem_addr=%h expected %h", imem.imem_addr, exp_fetch);
          end
        end
        if (inst_valid === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: pc_out=%h with no expected entry", pc_out);
          end else begin
            if (pc_out !== exp_q[0]) begin
              failures++;
              $display("FAIL sb_pc: pc_out=%h expected %h", pc_out, exp_q[0]);
            end
            checks++;
            if (pcPlus4_out !== exp_q[0] + 32'd4) begin
              failures++;
              $display("FAIL sb_pc4: pcPlus4_out=%h expected %h", pcPlus4_out, exp_q[0] + 32'd4);
            end
            checks++;
            if (inst !== word_of(exp_q[0])) begin
              failures++;
              $display("FAIL sb_inst: inst=%h expected %h", inst, word_of(exp_q[0]));
            end
            if (!stall && !redirect_valid) void'(exp_q.pop_front());
          end
        end
        if (redirect_valid) begin
          exp_q.delete();
          exp_fetch = redirect_pc & 32'hFFFF_FFFC;
        end else if (imem.imem_req_valid && imem.imem_req_ready) begin
          exp_q.push_back(exp_fetch);
          exp_fetch = exp_fetch + 32'd4;
        end
        if (imem.imem_req_valid && imem.imem_req_ready) pend_q.push_back(imem.imem_addr);
      end
    end
  endtask

  // Advance to just after the next rising edge; imem returns one word per cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!mem_hold && pend_q.size() > 0) begin
      imem.imem_rsp_valid = 1'b1;
      imem.imem_rsp_data  = word_of(pend_q.pop_front());
    end else begin
      imem.imem_rsp_valid = 1'b0;
    end
  endtask

  task automatic apply_reset();
    reset               = 1'b1;
    mon_en              = 1'b0;
    mem_hold            = 1'b0;
    stall               = 1'b0;
    redirect_valid      = 1'b0;
    redirect_pc         = 32'h0;
    imem.imem_req_ready = 1'b1;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = 32'h0;
    pend_q.delete();
    exp_q.delete();
    repeat (2) tick();
  endtask

  task automatic release_reset();
    reset     = 1'b0;
    exp_fetch = RESET_PC;
    mon_en    = 1'b1;
  endtask

  task automatic wait_valid(input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      tick();
      @(negedge clk);
      if (inst_valid === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++; if (imem.imem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid: got %b expected 0", imem.imem_req_valid); end
    checks++; if (imem.imem_addr !== RESET_PC) begin failures++; $display("FAIL rst_addr: got %h expected %h", imem.imem_addr, RESET_PC); end
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rst_inst_valid: got %b expected 0", inst_valid); end
    checks++; if (inst !== IDLE_INST_RST) begin failures++; $display("FAIL rst_inst: got %h expected %h", inst, IDLE_INST_RST); end
    checks++; if (pc_out !== RESET_PC) begin failures++; $display("FAIL rst_pc: got %h expected %h", pc_out, RESET_PC); end
    checks++; if (pcPlus4_out !== RESET_PC + 32'd4) begin failures++; $display("FAIL rst_pc4: got %h expected %h", pcPlus4_out, RESET_PC + 32'd4); end
    tick();
    release_reset();
    @(negedge clk);
    checks++; if (imem.imem_req_valid !== 1'b1) begin failures++; $display("FAIL first_req: req_valid=%b expected 1", imem.imem_req_valid); end
    tick();
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL lat_cycle1: inst_valid=%b expected 0", inst_valid); end
    tick();
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL lat_cycle2: inst_valid=%b expected 1", inst_valid); end
    checks++; if (pc_out !== RESET_PC) begin failures++; $display("FAIL lat_pc: pc_out=%h expected %h", pc_out, RESET_PC); end
  endtask

  task automatic test_stream();
    int n_valid = 0;
    repeat (10) begin
      tick();
      @(negedge clk);
      if (inst_valid === 1'b1) n_valid++;
    end
    checks++;
    if (n_valid != 10) begin failures++; $display("FAIL stream_rate: valid cycles=%0d expected 10", n_valid); end
  endtask

  task automatic test_stall();
    logic [31:0] frozen;
    tick();
    stall  = 1'b1;
    frozen = exp_q[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (pc_out !== frozen) begin failures++; $display("FAIL stall_freeze: cycle %0d pc_out=%h expected %h", i, pc_out, frozen); end
      if (i == 4) begin
        checks++;
        if (imem.imem_req_valid !== 1'b0) begin failures++; $display("FAIL stall_credit: req_valid=%b expected 0", imem.imem_req_valid); end
      end
      if (i < 4) tick();
    end
    tick();
    stall = 1'b0;
    @(negedge clk);
    checks++; if (pc_out !== frozen) begin failures++; $display("FAIL stall_release0: pc_out=%h expected %h", pc_out, frozen); end
    tick();
    @(negedge clk);
    checks++; if (pc_out !== frozen + 32'd4) begin failures++; $display("FAIL stall_release1: pc_out=%h expected %h", pc_out, frozen + 32'd4); end
    repeat (6) tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] a0;
    tick();
    imem.imem_req_ready = 1'b0;
    a0 = exp_fetch;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (imem.imem_req_valid !== 1'b1) begin failures++; $display("FAIL bp_valid: cycle %0d req_valid=%b expected 1", i, imem.imem_req_valid); end
      checks++; if (imem.imem_addr !== a0) begin failures++; $display("FAIL bp_addr: cycle %0d addr=%h expected %h", i, imem.imem_addr, a0); end
      tick();
    end
    imem.imem_req_ready = 1'b1;
    @(negedge clk);
    checks++; if (imem.imem_addr !== a0) begin failures++; $display("FAIL bp_xfer_addr: addr=%h expected %h", imem.imem_addr, a0); end
    tick();
    @(negedge clk);
    checks++; if (imem.imem_addr !== a0 + 32'd4) begin failures++; $display("FAIL bp_advance: addr=%h expected %h", imem.imem_addr, a0 + 32'd4); end
    repeat (4) tick();
  endtask

  task automatic test_redirect_discard();
    bit seen;
    tick();
    mem_hold = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++; if (imem.imem_req_valid !== 1'b0) begin failures++; $display("FAIL rd_outst_limit: req_valid=%b expected 0", imem.imem_req_valid); end
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rd_flush: inst_valid=%b expected 0", inst_valid); end
    tick();
    mem_hold = 1'b0;
    wait_valid(20, seen);
    checks++;
    if (!seen) begin failures++; $display("FAIL rd_timeout: inst_valid=0 expected 1 within 20 cycles"); end
    else if (pc_out !== 32'h0000_0100) begin failures++; $display("FAIL rd_target: pc_out=%h expected 00000100", pc_out); end
    repeat (5) tick();
  endtask

  task automatic test_redirect_latency();
    logic [31:0] head;
    logic [31:0] idle_exp;
    head = 32'h0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL rl_head: no instruction presented, expected one"); end
    else head = exp_q[0];
    idle_exp = NOP_MODE ? 32'h0000_0013 : word_of(head);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rl_t1: inst_valid=%b expected 0", inst_valid); end
    checks++; if (inst !== idle_exp) begin failures++; $display("FAIL rl_idle_inst: inst=%h expected %h", inst, idle_exp); end
    checks++; if (pc_out !== head) begin failures++; $display("FAIL rl_idle_pc: pc_out=%h expected %h", pc_out, head); end
    tick();
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rl_t2: inst_valid=%b expected 0", inst_valid); end
    tick();
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL rl_t3: inst_valid=%b expected 1", inst_valid); end
    checks++; if (pc_out !== 32'h0000_0200) begin failures++; $display("FAIL rl_target: pc_out=%h expected 00000200", pc_out); end
    repeat (4) tick();
  endtask

  task automatic test_wrap();
    bit seen;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    wait_valid(10, seen);
    checks++;
    if (!seen) begin failures++; $display("FAIL wrap_timeout: inst_valid=0 expected 1 within 10 cycles"); end
    else begin
      if (pc_out !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc: pc_out=%h expected fffffffc", pc_out); end
      checks++;
      if (pcPlus4_out !== 32'h0) begin failures++; $display("FAIL wrap_pc4: pcPlus4_out=%h expected 00000000", pcPlus4_out); end
    end
    tick();
    @(negedge clk);
    checks++; if (pc_out !== 32'h0 || inst_valid !== 1'b1) begin failures++; $display("FAIL wrap_next: pc_out=%h valid=%b expected 00000000 valid 1", pc_out, inst_valid); end
    repeat (4) tick();
  endtask

  task automatic test_stale_rsp();
    bit seen;
    apply_reset();
    imem.imem_req_ready = 1'b0;
    tick();
    release_reset();
    imem.imem_rsp_valid = 1'b1;
    imem.imem_rsp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL stale_c0: inst_valid=%b expected 0", inst_valid); end
    tick();
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL stale_c1: inst_valid=%b expected 0", inst_valid); end
    tick();
    imem.imem_req_ready = 1'b1;
    wait_valid(10, seen);
    checks++;
    if (!seen) begin failures++; $display("FAIL stale_timeout: inst_valid=0 expected 1 within 10 cycles"); end
    else if (pc_out !== RESET_PC) begin failures++; $display("FAIL stale_first_pc: pc_out=%h expected %h", pc_out, RESET_PC); end
    repeat (6) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_stream();
    test_stall();
    test_backpressure();
    test_redirect_discard();
    test_redirect_latency();
    test_wrap();
    test_stale_rsp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
